agc_track: RTL and testbench

AGC_TRACK -- requirements
Module: agc_track

---
 rtl/agc_track.sv | 157 +++++++++++++++
 tb/tb_agc_track.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/agc_track.sv
`default_nettype none
// agc_track: successive-approximation gain acquisition, then windowed overload tracking.
// Rev 1.0 - initial release.
module agc_track #(
  parameter int GAIN_W     = 6,
  parameter int SIG_W      = 4,
  parameter int SETTLE_LEN = 160,
  parameter int DETECT_LEN = 16,
  parameter int OVL_HI     = 4,
  parameter int QUIET_N    = 4
) (
  input  logic              clk,
  input  logic              RESETn,
  input  logic [SIG_W-1:0]  amplified_signal,
  input  logic              overload,
  input  logic              ext_or_int,
  input  logic              restart,
  input  logic              freeze,
  output logic [GAIN_W-1:0] gain,
  output logic              gain_upd,
  output logic              done,
  output logic              busy
);

  localparam int CYC_W = $clog2(SETTLE_LEN + DETECT_LEN + 1);
  localparam int OVC_W = $clog2(DETECT_LEN + 1);
  localparam int QN_W  = $clog2(QUIET_N + 1);
  localparam int K_W   = (GAIN_W > 1) ? $clog2(GAIN_W) : 1;
  localparam logic [GAIN_W-1:0] GAIN_INIT = GAIN_W'(1) << (GAIN_W - 1);

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_DETECT = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CYC_W-1:0]   r_cyc, w_cyc_nxt;
  logic [OVC_W-1:0]   r_ovc, w_ovc_nxt;
  logic [QN_W-1:0]    r_quiet, w_quiet_nxt;
  logic [K_W-1:0]     r_k, w_k_nxt;
  logic               r_track, w_track_nxt;
  logic [GAIN_W-1:0]  r_gain, w_gain_nxt;
  logic               r_upd;
  logic               w_ovl;
  logic [K_W-1:0]     w_k_dec;

  assign w_ovl   = ext_or_int ? overload : &amplified_signal;
  assign w_k_dec = r_k - K_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_cyc_nxt   = r_cyc;
    w_ovc_nxt   = r_ovc;
    w_quiet_nxt = r_quiet;
    w_k_nxt     = r_k;
    w_track_nxt = r_track;
    w_gain_nxt  = r_gain;

    case (r_state)
      ST_SETTLE: begin
        if (r_cyc == CYC_W'(SETTLE_LEN - 1)) begin
          w_state_nxt = ST_DETECT;
          w_cyc_nxt   = '0;
          w_ovc_nxt   = '0;
        end else begin
          w_cyc_nxt = r_cyc + CYC_W'(1);
        end
      end
      ST_DETECT: begin
        if (w_ovl && (r_ovc != OVC_W'(DETECT_LEN)))
          w_ovc_nxt = r_ovc + OVC_W'(1);
        if (r_cyc == CYC_W'(DETECT_LEN - 1)) begin
          w_state_nxt = ST_UPDATE;
          w_cyc_nxt   = '0;
        end else begin
          w_cyc_nxt = r_cyc + CYC_W'(1);
        end
      end
      ST_UPDATE: begin
        w_state_nxt = ST_SETTLE;
        w_cyc_nxt   = '0;
        if (!r_track) begin
          // Trial bit survives only an overload-free window.
          if (r_ovc != '0)
            w_gain_nxt[r_k] = 1'b0;
          if (r_k != '0) begin
            w_gain_nxt[w_k_dec] = 1'b1;
            w_k_nxt             = w_k_dec;
          end else begin
            w_track_nxt = 1'b1;
          end
        end else if (!freeze) begin
          if (r_ovc >= OVC_W'(OVL_HI)) begin
            if (r_gain != '0)
              w_gain_nxt = r_gain - GAIN_W'(1);
            w_quiet_nxt = '0;
          end else if (r_ovc == '0) begin
            if (r_quiet == QN_W'(QUIET_N - 1)) begin
              w_quiet_nxt = '0;
              if (r_gain != '1)
                w_gain_nxt = r_gain + GAIN_W'(1);
            end else begin
              w_quiet_nxt = r_quiet + QN_W'(1);
            end
          end else begin
            w_quiet_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_SETTLE;
        w_cyc_nxt   = '0;
      end
    endcase

    // Restart discards whatever decision was pending this cycle.
    if (restart) begin
      w_state_nxt = ST_SETTLE;
      w_cyc_nxt   = '0;
      w_ovc_nxt   = '0;
      w_quiet_nxt = '0;
      w_k_nxt     = K_W'(GAIN_W - 1);
      w_track_nxt = 1'b0;
      w_gain_nxt  = GAIN_INIT;
    end
  end

  always_ff @(posedge clk) begin
    if (!RESETn) begin
      r_state <= ST_SETTLE;
      r_cyc   <= '0;
      r_ovc   <= '0;
      r_quiet <= '0;
      r_k     <= K_W'(GAIN_W - 1);
      r_track <= 1'b0;
      r_gain  <= GAIN_INIT;
      r_upd   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cyc   <= w_cyc_nxt;
      r_ovc   <= w_ovc_nxt;
      r_quiet <= w_quiet_nxt;
      r_k     <= w_k_nxt;
      r_track <= w_track_nxt;
      r_gain  <= w_gain_nxt;
      r_upd   <= (w_gain_nxt != r_gain);
    end
  end

  assign gain     = r_gain;
  assign gain_upd = r_upd;
  assign done     = r_track;
  assign busy     = ~r_track;

endmodule
`default_nettype wire

// File: tb/tb_agc_track.sv
`default_nettype none
// tb_agc_track: randomized bench with an iteration-level reference model and an event scoreboard.
// Rev 1.0 - initial release.
module tb_agc_track;

  localparam int SL  = 160;
  localparam int DL  = 16;
  localparam int PER = SL + DL + 1;

  logic       clk = 1'b0;
  logic       RESETn = 1'b0;
  logic [3:0] amplified_signal = '0;
  logic       overload = 1'b0;
  logic       ext_or_int = 1'b1;
  logic       restart = 1'b0;
  logic       freeze = 1'b0;
  logic [5:0] gain;
  logic       gain_upd, done, busy;

  agc_track dut (
    .clk(clk), .RESETn(RESETn), .amplified_signal(amplified_signal),
    .overload(overload), .ext_or_int(ext_or_int), .restart(restart),
    .freeze(freeze), .gain(gain), .gain_upd(gain_upd), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int gain;
    bit done;
    bit upd;
  } ev_t;
  ev_t q[$];

  int checks = 0;
  int errors = 0;
  int upd_log[$];
  int done_rise = -1;
  int rel_cyc = 0;
  bit mon_en = 1'b0;
  bit prev_done = 1'b0;

  // Scenario knobs read by the driver.
  int ovl_mode = 0;
  int thr = 39;
  int sig_mode = 0;
  bit ext_sel = 1'b1;

  // Reference model: position within the run, gain, mode and counters.
  int m_t = 0, m_gain = 32, m_k = 5, m_quiet = 0, m_cnt = 0;
  bit m_track = 1'b0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(bit rstn, bit rs, bit frz, bit ovl);
    int g0;
    int ph;
    bit d0;
    bit upd;
    ev_t e;
    g0 = m_gain;
    d0 = m_track;
    if (!rstn || rs) begin
      m_gain = 32; m_k = 5; m_track = 1'b0; m_quiet = 0; m_cnt = 0; m_t = 0;
      upd = rstn && (g0 != 32);
    end else begin
      ph = m_t % PER;
      if (ph >= SL && ph < SL + DL) begin
        if (ph == SL) m_cnt = 0;
        if (ovl && m_cnt < DL) m_cnt++;
      end
      if (ph == SL + DL) begin
        if (!m_track) begin
          if (m_cnt > 0) m_gain = m_gain & ~(1 << m_k);
          if (m_k > 0) begin
            m_k--;
            m_gain = m_gain | (1 << m_k);
          end else begin
            m_track = 1'b1;
          end
        end else if (!frz) begin
          if (m_cnt >= 4) begin
            if (m_gain > 0) m_gain--;
            m_quiet = 0;
          end else if (m_cnt == 0) begin
            m_quiet++;
            if (m_quiet == 4) begin
              m_quiet = 0;
              if (m_gain < 63) m_gain++;
            end
          end else begin
            m_quiet = 0;
          end
        end
      end
      m_t++;
      upd = (m_gain != g0);
    end
    if (upd || m_track != d0) begin
      e.cyc = cyc + 1; e.gain = m_gain; e.done = m_track; e.upd = upd;
      q.push_back(e);
    end
  endtask

  task automatic tick(bit rstn, bit rs, bit frz);
    logic [3:0] s;
    bit oe;
    int ph;
    @(negedge clk);
    ph = m_t % PER;
    case (sig_mode)
      0:       s = 4'h0;
      1:       s = 4'($urandom);
      default: s = (ph >= SL && ph < SL + 3) ? 4'hF : 4'($urandom_range(0, 14));
    endcase
    case (ovl_mode)
      0:       oe = 1'b0;
      1:       oe = 1'b1;
      2:       oe = (m_gain > thr);
      default: oe = ($urandom_range(0, 7) == 0);
    endcase
    RESETn = rstn; restart = rs; freeze = frz; ext_or_int = ext_sel;
    overload = oe; amplified_signal = s;
    if (!rstn || rs) rel_cyc = cyc + 1;
    model_step(rstn, rs, frz, ext_sel ? oe : (s == 4'hF));
  endtask

  task automatic run(int n, bit frz);
    repeat (n) tick(1'b1, 1'b0, frz);
  endtask

  task automatic chk_reset_vals(string tag);
    @(posedge clk);
    #1;
    check({tag, "_gain"}, int'(gain), 32);
    check({tag, "_upd"}, int'(gain_upd), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_busy"}, int'(busy), 1);
  endtask

  // Monitor: every gain_upd pulse or done edge must match the next queued event.
  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
          e = q.pop_front();
          checks++; errors++;
          $display("FAIL missed_event: at cycle %0d expected gain=%0d done=%0d upd=%0d, no DUT event",
                   e.cyc, e.gain, e.done, e.upd);
        end
        if (gain_upd || done !== prev_done) begin
          checks++;
          if (q.size() == 0 || q[0].cyc != cyc) begin
            errors++;
            $display("FAIL unexpected_event: cycle %0d gain=%0d done=%0d upd=%0d, none expected",
                     cyc, gain, done, gain_upd);
          end else begin
            e = q.pop_front();
            if (int'(gain) != e.gain || done !== e.done || busy !== !e.done || gain_upd !== e.upd) begin
              errors++;
              $display("FAIL event: cycle %0d got gain=%0d done=%0d busy=%0d upd=%0d expected gain=%0d done=%0d busy=%0d upd=%0d",
                       cyc, gain, done, busy, gain_upd, e.gain, e.done, !e.done, e.upd);
            end
          end
        end
        if (gain_upd) upd_log.push_back(int'(gain));
        if (done && !prev_done) done_rise = cyc;
      end
      prev_done = done;
    end
  end

  initial begin
    int exp_seq[5];
    exp_seq = '{48, 40, 36, 38, 39};

    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    chk_reset_vals("reset");

    // Acquisition against a gain > 39 overload threshold.
    ovl_mode = 2; thr = 39; ext_sel = 1'b1; sig_mode = 0;
    upd_log.delete(); done_rise = -1;
    run(PER * 6 + 5, 1'b0);
    check("acq39_done_time", done_rise - rel_cyc, 1062);
    check("acq39_gain", int'(gain), 39);
    check("acq39_seq_len", upd_log.size(), 5);
    if (upd_log.size() == 5)
      for (int i = 0; i < 5; i++) check("acq39_seq", upd_log[i], exp_seq[i]);

    // Tracking down to a new threshold of 30.
    thr = 30; upd_log.delete();
    run(PER * 16, 1'b0);
    check("track30_gain", int'(gain), 30);
    check("track30_pulses", upd_log.size(), 11);

    // Freeze against a solid overload, then restart landing on an UPDATE cycle.
    ovl_mode = 1;
    run(PER * 3, 1'b1);
    check("freeze_gain", int'(gain), 30);
    while (m_t % PER != PER - 1) tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("restart_gain", int'(gain), 32);
    check("restart_busy", int'(busy), 1);
    check("restart_upd", int'(gain_upd), 1);

    done_rise = -1;
    run(PER * 6 + 4, 1'b0);
    check("tied1_gain", int'(gain), 0);
    check("tied1_done_time", done_rise - rel_cyc, 1062);

    // Overload never asserted.
    ovl_mode = 0; done_rise = -1;
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    run(PER * 6 + 5, 1'b0);
    check("tied0_gain", int'(gain), 63);
    check("tied0_done_time", done_rise - rel_cyc, 1062);

    ovl_mode = 2; thr = 50;
    run(PER * 14, 1'b0);
    check("track50_gain", int'(gain), 50);

    // Internal detection, three full-scale samples per window: below the decrement threshold.
    ext_sel = 1'b0; sig_mode = 2; upd_log.delete();
    run(PER * 6, 1'b0);
    check("int3_gain", int'(gain), 50);
    check("int3_pulses", upd_log.size(), 0);
    sig_mode = 0;
    run(PER * 5, 1'b0);
    check("quiet_step_gain", int'(gain), 51);

    // Randomized source, samples, freeze and rare restarts.
    sig_mode = 1; ovl_mode = 3;
    for (int w = 0; w < 20; w++) begin
      ext_sel = 1'($urandom_range(0, 1));
      for (int i = 0; i < PER; i++)
        tick(1'b1, $urandom_range(0, 2999) == 0, $urandom_range(0, 3) == 0);
    end

    // One-cycle reset inside a DETECT window, then a clean reacquisition.
    while (m_t % PER != SL + 5) tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk_reset_vals("midreset");
    ovl_mode = 2; thr = 39; ext_sel = 1'b1; sig_mode = 0; done_rise = -1;
    run(PER * 6 + 5, 1'b0);
    check("reacq_gain", int'(gain), 39);
    check("reacq_done_time", done_rise - rel_cyc, 1062);

    run(5, 1'b0);
    check("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
